// File: rtl/alu_op_sequencer.sv
// Issue/capture wrapper around a slow-settling structural ALU: registers one operation,
// waits a fixed number of edges for the ripple carry to settle, then captures the result.
module alu_op_sequencer #(
  parameter int unsigned Width        = 32,
  parameter int unsigned SettleCycles = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_a_i,
  input  logic [Width-1:0] in_b_i,
  input  logic [2:0]       in_cmd_i,
  output logic [Width-1:0] alu_a_o,
  output logic [Width-1:0] alu_b_o,
  output logic [2:0]       alu_cmd_o,
  input  logic [Width-1:0] alu_res_i,
  input  logic             alu_carryout_i,
  input  logic             alu_overflow_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_res_o,
  output logic             out_carryout_o,
  output logic             out_overflow_o,
  output logic             out_zero_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

  localparam logic [7:0] CntLoad = 8'(SettleCycles - 1);

  state_e           state_q;
  logic [7:0]       cnt_q;
  logic [Width-1:0] alu_a_q, alu_b_q, out_res_q;
  logic [2:0]       alu_cmd_q;
  logic             out_valid_q, out_carryout_q, out_overflow_q, out_zero_q;
  logic             accept;

  always_comb begin
    in_ready_o = (state_q == StIdle) || ((state_q == StHold) && out_ready_i);
    accept     = in_valid_i && in_ready_o;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_cmd_q      <= '0;
      out_res_q      <= '0;
      out_carryout_q <= 1'b0;
      out_overflow_q <= 1'b0;
      out_zero_q     <= 1'b0;
      out_valid_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StHold: begin
          // In HOLD, accept implies out_ready, so the handshake and the new issue share an edge
          if (accept) begin
            alu_a_q     <= in_a_i;
            alu_b_q     <= in_b_i;
            alu_cmd_q   <= in_cmd_i;
            cnt_q       <= CntLoad;
            out_valid_q <= 1'b0;
            state_q     <= StSettle;
          end else if ((state_q == StHold) && out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        StSettle: begin
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            out_res_q      <= alu_res_i;
            out_carryout_q <= alu_carryout_i;
            out_overflow_q <= alu_overflow_i;
            out_zero_q     <= ~|alu_res_i;
            out_valid_q    <= 1'b1;
            state_q        <= StHold;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    alu_a_o        = alu_a_q;
    alu_b_o        = alu_b_q;
    alu_cmd_o      = alu_cmd_q;
    out_valid_o    = out_valid_q;
    out_res_o      = out_res_q;
    out_carryout_o = out_carryout_q;
    out_overflow_o = out_overflow_q;
    out_zero_o     = out_zero_q;
    busy_o         = (state_q == StSettle);
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU whose outputs lag its inputs
// by 1500 time units, so only a correctly timed capture sees the right answer.
module tb_alu_op_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i, in_ready_o;
  logic [31:0] in_a_i, in_b_i;
  logic [2:0]  in_cmd_i;
  logic [31:0] alu_a_o, alu_b_o;
  logic [2:0]  alu_cmd_o;
  logic [31:0] alu_res_i;
  logic        alu_carryout_i, alu_overflow_i;
  logic        out_valid_o, out_ready_i;
  logic [31:0] out_res_o;
  logic        out_carryout_o, out_overflow_o, out_zero_o, busy_o;

  int checks = 0;
  int errors = 0;

  logic        model_en;
  logic [33:0] model_v;
  logic [33:0] force_v;

  always #50 clk_i = ~clk_i;

  alu_op_sequencer #(.Width(32), .SettleCycles(16)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_a_i         (in_a_i),
    .in_b_i         (in_b_i),
    .in_cmd_i       (in_cmd_i),
    .alu_a_o        (alu_a_o),
    .alu_b_o        (alu_b_o),
    .alu_cmd_o      (alu_cmd_o),
    .alu_res_i      (alu_res_i),
    .alu_carryout_i (alu_carryout_i),
    .alu_overflow_i (alu_overflow_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_res_o      (out_res_o),
    .out_carryout_o (out_carryout_o),
    .out_overflow_o (out_overflow_o),
    .out_zero_o     (out_zero_o),
    .busy_o         (busy_o)
  );

  // {carryout, overflow, result}
  function automatic logic [33:0] alu_f(logic [31:0] a, logic [31:0] b, logic [2:0] c);
    logic [32:0] s;
    logic [31:0] r;
    logic        ov;
    s  = '0;
    ov = 1'b0;
    case (c)
      3'd0: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[31:0];
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd1: begin
        s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r  = s[31:0];
        ov = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'd2:    r = a ^ b;
      3'd3:    r = {31'd0, $signed(a) < $signed(b)};
      3'd4:    r = a & b;
      3'd5:    r = ~(a & b);
      3'd6:    r = ~(a | b);
      default: r = a | b;
    endcase
    return {s[32], ov, r};
  endfunction

  always @(alu_a_o or alu_b_o or alu_cmd_o) model_v <= #1500 alu_f(alu_a_o, alu_b_o, alu_cmd_o);

  assign {alu_carryout_i, alu_overflow_i, alu_res_i} = model_en ? model_v : force_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    in_valid_i = 1'b1;
    in_a_i     = a;
    in_b_i     = b;
    in_cmd_i   = c;
    tick();
    in_valid_i = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid appears; bounded.
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid_o && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic drain();
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] c, input logic [31:0] exp_res);
    int n;
    issue(a, b, c);
    wait_out(n);
    chk({tag, "_lat"}, n, 16);
    chk({tag, "_res"}, out_res_o, exp_res);
    chk({tag, "_zero"}, {31'd0, out_zero_o}, {31'd0, exp_res == 32'd0});
    drain();
  endtask

  initial begin
    int  n;
    logic seen;
    model_en    = 1'b1;
    force_v     = '0;
    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    in_a_i      = '0;
    in_b_i      = '0;
    in_cmd_i    = '0;
    out_ready_i = 1'b0;
    #10;
    chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_out_res", out_res_o, 32'd0);
    chk("rst_out_zero", {31'd0, out_zero_o}, 32'd0);
    chk("rst_alu_a", alu_a_o, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    chk("rst_in_ready", {31'd0, in_ready_o}, 32'd1);

    // ADD overflow: exact capture edge N+16
    issue(32'h7FFF_FFFF, 32'h0000_0001, 3'd0);
    chk("add_busy", {31'd0, busy_o}, 32'd1);
    chk("add_in_ready", {31'd0, in_ready_o}, 32'd0);
    chk("add_alu_a", alu_a_o, 32'h7FFF_FFFF);
    for (int i = 0; i < 15; i++) tick();
    chk("add_not_early", {31'd0, out_valid_o}, 32'd0);
    tick();
    chk("add_valid", {31'd0, out_valid_o}, 32'd1);
    chk("add_res", out_res_o, 32'h8000_0000);
    chk("add_ovf", {31'd0, out_overflow_o}, 32'd1);
    chk("add_cout", {31'd0, out_carryout_o}, 32'd0);
    chk("add_zero", {31'd0, out_zero_o}, 32'd0);
    drain();
    chk("add_drained", {31'd0, out_valid_o}, 32'd0);
    chk("add_idle_ready", {31'd0, in_ready_o}, 32'd1);
    chk("add_alu_a_held", alu_a_o, 32'h7FFF_FFFF);

    // SUB equal
    issue(32'd5, 32'd5, 3'd1);
    wait_out(n);
    chk("sub_lat", n, 16);
    chk("sub_res", out_res_o, 32'd0);
    chk("sub_zero", {31'd0, out_zero_o}, 32'd1);
    chk("sub_cout", {31'd0, out_carryout_o}, 32'd1);
    chk("sub_ovf", {31'd0, out_overflow_o}, 32'd0);

    // Backpressure with a pending request
    in_valid_i = 1'b1;
    in_a_i     = 32'd3;
    in_b_i     = 32'd4;
    in_cmd_i   = 3'd0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_in_ready", {31'd0, in_ready_o}, 32'd0);
      chk("bp_valid", {31'd0, out_valid_o}, 32'd1);
      chk("bp_res", out_res_o, 32'd0);
      chk("bp_alu_a", alu_a_o, 32'd5);
      tick();
    end
    out_ready_i = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready_o}, 32'd1);
    tick();
    out_ready_i = 1'b0;
    in_valid_i  = 1'b0;
    chk("bp_valid_drop", {31'd0, out_valid_o}, 32'd0);
    chk("bp_busy", {31'd0, busy_o}, 32'd1);
    chk("bp_alu_a_new", alu_a_o, 32'd3);
    wait_out(n);
    chk("bp_lat", n, 16);
    chk("bp_res7", out_res_o, 32'd7);
    drain();

    // Reset while cnt=5 (ten edges after accept)
    issue(32'h11, 32'h22, 3'd7);
    for (int i = 0; i < 10; i++) tick();
    #5;
    rst_i = 1'b1;
    #1;
    chk("rs_alu_a", alu_a_o, 32'd0);
    chk("rs_alu_cmd", {29'd0, alu_cmd_o}, 32'd0);
    chk("rs_busy", {31'd0, busy_o}, 32'd0);
    tick();
    rst_i = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen |= out_valid_o;
    end
    chk("rs_no_valid", {31'd0, seen}, 32'd0);
    run_op("rs_next_xor", 32'h0000_F0F0, 32'h0000_0FF0, 3'd2, 32'h0000_FF00);

    // Directed ops across the remaining commands
    run_op("slt", 32'hFFFF_FFFF, 32'h0000_0001, 3'd3, 32'h0000_0001);
    run_op("and", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd4, 32'hF000_F000);
    run_op("nand", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd5, 32'h0FFF_0FFF);
    run_op("nor", 32'h0000_0000, 32'h0000_0000, 3'd6, 32'hFFFF_FFFF);

    // Asynchronous reset asserted in HOLD, mid high phase
    issue(32'h1, 32'h1, 3'd0);
    wait_out(n);
    chk("hr_valid", {31'd0, out_valid_o}, 32'd1);
    @(posedge clk_i);
    #20;
    rst_i = 1'b1;
    #1;
    chk("hr_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("hr_out_res", out_res_o, 32'd0);
    chk("hr_alu_a", alu_a_o, 32'd0);
    tick();
    rst_i = 1'b0;
    tick();

    // No early capture: ALU output changes only after edge N+15
    model_en = 1'b0;
    force_v  = {2'b00, 32'hDEAD_BEEF};
    issue(32'h1, 32'h2, 3'd0);
    for (int i = 0; i < 15; i++) tick();
    chk("ne_not_yet", {31'd0, out_valid_o}, 32'd0);
    force_v = {2'b00, 32'h0000_0010};
    tick();
    chk("ne_valid", {31'd0, out_valid_o}, 32'd1);
    chk("ne_res", out_res_o, 32'h0000_0010);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Issue/capture stage wrapped around the 32-bit structural ALU; the ALU's gate-level ripple carry needs many clock periods to settle.
- Accepts one operation per valid/ready handshake and drives registered operands and command into the ALU.
- Waits a fixed settle interval, then captures result, carryout and overflow, and generates the zero flag the ALU top level lacks.
- Presents the captured result downstream with valid/ready backpressure.

Parameters:
- WIDTH, 32, operand/result width.
- SETTLE_CYCLES, 16, clock edges from accept to capture; legal range 1..255.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted on edge where in_valid&in_ready.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cmd  input  3  0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR.
- alu_a  output  WIDTH  registered operand A to ALU.
- alu_b  output  WIDTH  registered operand B to ALU.
- alu_cmd  output  3  registered command to ALU.
- alu_res  input  WIDTH  ALU result.
- alu_carryout  input  1  ALU carryout.
- alu_overflow  input  1  ALU overflow.
- out_valid  output  1  captured result valid.
- out_ready  input  1  downstream accepts on out_valid&out_ready.
- out_res  output  WIDTH  captured result.
- out_carryout  output  1  captured carryout.
- out_overflow  output  1  captured overflow.
- out_zero  output  1  1 when captured result is all zeros.
- busy  output  1  high in SETTLE.

Behaviour:
- Reset (async, immediate): state=IDLE; cnt=0; alu_a, alu_b, alu_cmd=0; out_res=0; out_carryout, out_overflow, out_zero=0; out_valid=0; busy=0.
- Reset is honoured in any state. An op in SETTLE is abandoned, nothing is captured, and out_valid stays 0.
- States: IDLE, SETTLE, HOLD.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). It is combinational and never asserted in SETTLE.
- Accept (in_valid&in_ready at edge N):
  - alu_a<=in_a, alu_b<=in_b, alu_cmd<=in_cmd.
  - cnt<=SETTLE_CYCLES-1; state<=SETTLE.
  - If accepted from HOLD, out_valid<=0 on the same edge.
- SETTLE:
  - cnt!=0 → cnt<=cnt-1.
  - cnt==0 → out_res<=alu_res, out_carryout<=alu_carryout, out_overflow<=alu_overflow, out_zero<=~|alu_res, out_valid<=1, state<=HOLD.
  - Capture therefore occurs at edge N+SETTLE_CYCLES. ALU values at earlier edges are ignored.
- HOLD:
  - out_valid=1. out_* and alu_* are held stable until handshake.
  - out_ready & !in_valid → out_valid<=0, state<=IDLE.
  - out_ready & in_valid → accept as above; back-to-back throughput is one op per SETTLE_CYCLES+1 edges.
- alu_a, alu_b, alu_cmd change only on accept. They are otherwise stable in all states, including IDLE after completion.
- Request inputs are ignored when in_ready=0. No queuing.
- busy=(state==SETTLE).
- out_valid never deasserts without out_ready or reset.
- Arithmetic is entirely in the ALU. The block performs no width extension. out_zero is computed from the full WIDTH result.

Test Plan:
- Reset:
  - Stimulus: assert reset mid-cycle.
  - Required: all outputs 0 without waiting for clk; in_ready=1 after release.
- ADD overflow:
  - Stimulus: cmd=0, a=0x7FFFFFFF, b=0x00000001, accepted at edge N; bench ALU model has 1500-unit delay, clk period 100.
  - Required: out_valid rises at edge N+16; out_res=0x80000000, overflow=1, carryout=0, zero=0.
- SUB equal:
  - Stimulus: cmd=1, a=5, b=5.
  - Required: out_res=0, out_zero=1, out_carryout=1, out_overflow=0.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid; in_valid=1 with a=3, b=4, cmd=0.
  - Required: out_* stable; in_ready=0 throughout.
  - Stimulus: then out_ready=1 for one cycle.
  - Required: new op accepted on that edge; out_valid=0 next cycle; out_res=7 after 16 more edges.
- Reset mid-SETTLE:
  - Stimulus: assert reset when cnt=5.
  - Required: alu_a=0 immediately; out_valid stays 0 after release; next op completes normally.
- No early capture:
  - Stimulus: bench ALU drives alu_res=0xDEADBEEF until one cycle before the capture edge, then 0x00000010.
  - Required: out_res=0x00000010.
